// File: rtl/reg_bus_master.sv
// reg_bus_master
//
// Command sequencer that sits directly upstream of a small register block and
// is the only driver of its wr_en/addr_vld/addr/din inputs. Read/write
// commands arrive on a valid/ready port and queue in a FIFO. Each command
// becomes exactly one register-bus access, and each command gets exactly one
// response, returned in command order on a valid/ready port. Addresses at or
// above NUM_REGS are rejected without touching the bus. Reads that see no
// reg_dout_vld within TIMEOUT cycles are answered with an error. Error
// responses are counted in a saturating 8-bit counter.
//
// Optional build macro: REG_MST_WR_VERIFY_EN
//   When defined, every write is followed by a one-cycle read of the same
//   address (VRFY_ISSUE) and a wait for its data (VRFY_WAIT, same timeout
//   rule). A read-back that differs from the written data, or a timeout, sets
//   rsp_err. rsp_rdata carries the read-back value, or 0 on timeout.
//   When undefined, writes respond one cycle after their bus access, with
//   rdata = 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (cmd_ready = FIFO not full)
//   cmd_wr/addr/wdata   command type (1 = write), address, write data
//   rsp_valid/ready     response handshake
//   rsp_wr/rdata/err    echoed type, read data (0 for writes/errors), error
//   reg_wr_en/addr_vld  register-bus strobes (single-cycle pulses)
//   reg_addr/din        register-bus address and write data
//   reg_dout/dout_vld   register-bus read data and its valid
//   busy                FSM not idle or FIFO non-empty
//   err_cnt             saturating count of error responses
module reg_bus_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              reg_wr_en,
   output logic              reg_addr_vld,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_din,
   input  logic [DATA_W-1:0] reg_dout,
   input  logic              reg_dout_vld,
   output logic              busy,
   output logic [7:0]        err_cnt
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [PTR_W:0]   DEPTH_L    = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]  NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RD,
      ST_RESP
`ifdef REG_MST_WR_VERIFY_EN
      , ST_VRFY_ISSUE
      , ST_VRFY_WAIT
`endif
   } state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   state_t            state_q;
   logic              rsp_valid_q, rsp_wr_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              reg_wr_en_q, reg_addr_vld_q;
   logic [ADDR_W-1:0] reg_addr_q;
   logic [DATA_W-1:0] reg_din_q;
   logic [7:0]        err_cnt_q;
   logic [CNT_W-1:0]  wait_cnt_q;
`ifdef REG_MST_WR_VERIFY_EN
   logic [DATA_W-1:0] wdata_q;
`endif

   // ---------------------------------------------------------------- FIFO
   cmd_t             fifo_mem [FIFO_DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full, empty, push, pop, head_oor;

   assign full      = (count_q == DEPTH_L);
   assign empty     = (count_q == '0);
   // Ready depends only on full, so a full FIFO refuses even when popping.
   assign push      = cmd_valid && !full;
   assign pop       = (state_q == ST_IDLE) && !empty;
   assign head      = fifo_mem[rd_ptr_q];
   assign head_oor  = ({1'b0, head.addr} >= NUM_REGS_L);
   assign cmd_ready = !full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {cmd_wr, cmd_addr, cmd_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ----------------------------------------------------------------- FSM
   // reg_addr/reg_din are left holding after a pulse; only the strobes drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rsp_valid_q    <= 1'b0;
         rsp_wr_q       <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_err_q      <= 1'b0;
         reg_wr_en_q    <= 1'b0;
         reg_addr_vld_q <= 1'b0;
         reg_addr_q     <= '0;
         reg_din_q      <= '0;
         err_cnt_q      <= '0;
         wait_cnt_q     <= '0;
`ifdef REG_MST_WR_VERIFY_EN
         wdata_q        <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!empty) begin
                  if (head_oor) begin
                     rsp_valid_q <= 1'b1;
                     rsp_wr_q    <= head.wr;
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     reg_addr_vld_q <= 1'b1;
                     reg_wr_en_q    <= head.wr;
                     reg_addr_q     <= head.addr;
                     reg_din_q      <= head.wr ? head.wdata : '0;
`ifdef REG_MST_WR_VERIFY_EN
                     wdata_q        <= head.wdata;
`endif
                     state_q        <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               reg_addr_vld_q <= 1'b0;
               reg_wr_en_q    <= 1'b0;
               wait_cnt_q     <= '0;
               // reg_wr_en_q still tells us which kind of access this was.
               if (reg_wr_en_q) begin
`ifdef REG_MST_WR_VERIFY_EN
                  reg_addr_vld_q <= 1'b1;
                  reg_din_q      <= '0;
                  state_q        <= ST_VRFY_ISSUE;
`else
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= ST_RESP;
`endif
               end else begin
                  state_q <= ST_WAIT_RD;
               end
            end
            ST_WAIT_RD: begin
               if (reg_dout_vld) begin
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= 1'b0;
                  rsp_rdata_q <= reg_dout;
                  rsp_err_q   <= 1'b0;
                  state_q     <= ST_RESP;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
`ifdef REG_MST_WR_VERIFY_EN
            ST_VRFY_ISSUE: begin
               reg_addr_vld_q <= 1'b0;
               wait_cnt_q     <= '0;
               state_q        <= ST_VRFY_WAIT;
            end
            ST_VRFY_WAIT: begin
               if (reg_dout_vld) begin
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= 1'b1;
                  rsp_rdata_q <= reg_dout;
                  rsp_err_q   <= (reg_dout != wdata_q);
                  state_q     <= ST_RESP;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
`endif
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
                  if (rsp_err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_wr       = rsp_wr_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;
   assign reg_wr_en    = reg_wr_en_q;
   assign reg_addr_vld = reg_addr_vld_q;
   assign reg_addr     = reg_addr_q;
   assign reg_din      = reg_din_q;
   assign err_cnt      = err_cnt_q;
   assign busy         = (state_q != ST_IDLE) || !empty;

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Command sequencer directly upstream of the 4-entry register block; sole driver of its wr_en/addr_vld/addr/din interface.
- Accepts read/write commands on a valid/ready port and buffers them in a small FIFO.
- Issues one register-bus access per command, captures read data on dout_vld, and returns exactly one response per command on a valid/ready response port.
- Adds out-of-range address rejection, read timeout and an error counter.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
- ADDR_W, 3, register address width.
- DATA_W, 32, data width.
- NUM_REGS, 4, addresses >= NUM_REGS are rejected without a bus access.
- TIMEOUT, 8, cycles spent in WAIT_RD without reg_dout_vld before an error response.

Ports:
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- cmd_valid in 1: command valid.
- cmd_ready out 1: FIFO can accept; equals !full.
- cmd_wr in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_W: register address.
- cmd_wdata in DATA_W: write data.
- rsp_valid out 1: response valid.
- rsp_ready in 1: response consumed.
- rsp_wr out 1: echo of the command type.
- rsp_rdata out DATA_W: read data; 0 for writes and errors.
- rsp_err out 1: out-of-range address or timeout.
- reg_wr_en out 1: to register block wr_en.
- reg_addr_vld out 1: to register block addr_vld.
- reg_addr out ADDR_W: to register block addr.
- reg_din out DATA_W: to register block din.
- reg_dout in DATA_W: from register block dout.
- reg_dout_vld in 1: from register block dout_vld.
- busy out 1: FSM not IDLE or FIFO non-empty.
- err_cnt out 8: count of error responses, saturates at 255.

Behaviour:
- Clock and reset: all state updates on posedge clk. Interface is one clock; reset is synchronous and active-high.
- Reset values: rsp_valid = 0, rsp_wr = 0, rsp_rdata = 0, rsp_err = 0, reg_wr_en = 0, reg_addr_vld = 0, reg_addr = 0, reg_din = 0, err_cnt = 0, busy = 0. FIFO is empty, so cmd_ready = 1. FSM is in IDLE.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready depends on full only; no push when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full; the occupancy count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head.
  - If addr >= NUM_REGS, go to RESP with rsp_err = 1 and rdata = 0; no bus access.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle; all reg_* outputs registered):
  - reg_addr_vld = 1, reg_wr_en = cmd_wr, reg_addr = addr, reg_din = wdata (writes), 0 (reads).
  - Write: go to RESP with err = 0.
  - Read: go to WAIT_RD.
- Leaving ISSUE: reg_addr_vld and reg_wr_en return to 0 the next cycle. The bus is never held for more than one cycle.
- WAIT_RD:
  - When reg_dout_vld = 1: capture reg_dout into rsp_rdata, go to RESP with err = 0.
  - A wait counter starts at 0 on entry. If it reaches TIMEOUT first, go to RESP with err = 1 and rdata = 0.
  - reg_dout_vld seen outside WAIT_RD is ignored.
- RESP:
  - rsp_valid = 1; rsp_* fields stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - The next FIFO pop may occur in the first IDLE cycle; no back-to-back pop out of RESP.
- Latency with command handshake in cycle N and rsp_ready held high:
  - Bus access in cycle N+2.
  - Write: rsp_valid in N+3.
  - Read: reg_dout_vld expected in N+3, rsp_valid in N+4.
  - Out-of-range: rsp_valid in N+2.
- err_cnt: increments by 1 at each error-response handshake; holds at 255.
- Responses are returned in command order.
- Reset mid-operation: FIFO is flushed, any pending response is dropped, bus outputs go to 0 in the reset cycle, FSM goes to IDLE.

Optional Feature:
REG_MST_WR_VERIFY_EN
- Defined:
  - After a write's ISSUE, add states VRFY_ISSUE (1-cycle read of the same address, reg_wr_en = 0) and VRFY_WAIT (same timeout rule as WAIT_RD).
  - Read-back != written data, or a timeout, gives rsp_err = 1.
  - rsp_rdata = read-back value (0 on timeout).
  - Write response latency becomes N+5.
- Undefined: states are absent; writes respond at N+3 with rdata = 0.

Test Plan:
- Write addr 2 data 0xDEADBEEF, then read addr 2 -> reg_addr_vld & reg_wr_en pulse 1 cycle at N+2; write rsp at N+3 err = 0; read rsp rdata = 0xDEADBEEF err = 0 at N+4 relative to its own handshake.
- Push 5 commands with rsp_ready = 0 and FIFO_DEPTH = 4 -> cmd_ready drops after the FIFO fills; rsp_valid held stable; releasing rsp_ready drains all 5 in order with correct data.
- Read addr 5 -> no bus access (reg_addr_vld stays 0), rsp_err = 1, rdata = 0, err_cnt = 1.
- Read addr 1 with reg_dout_vld forced 0 -> rsp_err = 1 after 8 cycles in WAIT_RD; err_cnt increments; next command proceeds normally.
- Assert rst while in WAIT_RD with 2 commands queued -> next cycle: FIFO empty, cmd_ready = 1, busy = 0, rsp_valid = 0, err_cnt = 0.
- Back-to-back writes to addrs 0,1,2,3 with rsp_ready = 1 -> bus pulses separated by >= 2 cycles; readback of all four matches (with REG_MST_WR_VERIFY_EN, a corrupted read-back gives err = 1).
